bus_slave_mem: RTL



---
 rtl/bus_slave_mem_pkg.sv | 32 +++
 rtl/bus_slave_ram.sv | 31 +++
 rtl/bus_slave_mem.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bus_slave_mem_pkg.sv
// Shared constants and types for the bus_slave_mem responder:
// bus direction levels, active-low enable levels, FSM state encoding
// and the data word width.
package bus_slave_mem_pkg;

  // Bus direction carried on rw
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Active-low strobe levels used on cs_, as_ and rdy_
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Data word width of the bus and the RAM
  localparam int WORD_W = 32;

  // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
  localparam int CNT_W = 4;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // True when both the decoder select and the master strobe are asserted
  function automatic logic req_active(input logic cs_n, input logic as_n);
    return (cs_n == ENABLE_) && (as_n == ENABLE_);
  endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// Word-addressed RAM behind bus_slave_mem: 2^DEPTH_LOG2 words of WORD_W bits,
// combinational read port and synchronous write port with write enable.
// Contents are deliberately not reset.
module bus_slave_ram
  import bus_slave_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];

  // Synchronous write of one word when enabled
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read of the addressed word
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/bus_slave_mem.sv
// Bus responder backing a word-addressed RAM. One request at a time is
// accepted in IDLE, WAIT_CYCLES wait states follow, then rdy_ pulses low
// for one cycle. rd_data is zero outside a read acknowledge so slaves can
// be OR-combined on the bus.
// Optional write protect: define BUS_SLAVE_MEM_WP_EN to add the wp input
// and wp_err output; protected writes are acknowledged but not committed.
module bus_slave_mem
  import bus_slave_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [29:0]       addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] rd_data,
`ifdef BUS_SLAVE_MEM_WP_EN
  input  logic              wp,
  output logic              wp_err,
`endif
  output logic              rdy_
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic                    rdy_q, rdy_d;
  logic [WORD_W-1:0]       rd_data_q, rd_data_d;
  logic                    accept_s;
  logic                    wp_block_s;
  logic                    ram_we_s;
  logic [WORD_W-1:0]       ram_rdata_s;
  logic                    unused_addr_s;

  // Upper address bits are ignored so the RAM aliases on wrap
  assign unused_addr_s = &{1'b0, addr[29:DEPTH_LOG2]};

  assign accept_s = (state_q == IDLE) && req_active(cs_, as_);

  // Next-state, wait counter and request latching
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          addr_d  = addr[DEPTH_LOG2-1:0];
          rw_d    = rw;
          wdata_d = wr_data;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Master abort has priority over an expiring counter
        if ((as_ == DISABLE_) || (cs_ == DISABLE_)) begin
          state_d = IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the next state so that rdy_ and
  // rd_data line up with the ACK cycle itself
  always_comb begin
    if (state_d == ACK) begin
      rdy_d = ENABLE_;
    end else begin
      rdy_d = DISABLE_;
    end
    if ((state_d == ACK) && (rw_d == READ)) begin
      rd_data_d = ram_rdata_s;
    end else begin
      rd_data_d = {WORD_W{1'b0}};
    end
  end

  // State, latched request and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      addr_q    <= {DEPTH_LOG2{1'b0}};
      rw_q      <= READ;
      wdata_q   <= {WORD_W{1'b0}};
      rdy_q     <= DISABLE_;
      rd_data_q <= {WORD_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef BUS_SLAVE_MEM_WP_EN
  logic wp_q, wp_d;
  logic wp_err_q, wp_err_d;

  // Capture write protect at acceptance and flag protected write acks
  always_comb begin
    if (accept_s) begin
      wp_d = wp;
    end else begin
      wp_d = wp_q;
    end
    if ((state_d == ACK) && (rw_d == WRITE) && wp_d) begin
      wp_err_d = 1'b1;
    end else begin
      wp_err_d = 1'b0;
    end
  end

  // Write-protect registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q     <= 1'b0;
      wp_err_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      wp_err_q <= wp_err_d;
    end
  end

  assign wp_block_s = wp_q;
  assign wp_err     = wp_err_q;
`else
  assign wp_block_s = 1'b0;
`endif

  // Commit happens on the edge that ends ACK
  assign ram_we_s = (state_q == ACK) && (rw_q == WRITE) && !wp_block_s;

  bus_slave_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_d),
    .rdata_o (ram_rdata_s)
  );

  assign rdy_    = rdy_q;
  assign rd_data = rd_data_q;

endmodule
